hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 174 +++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard detector: tracks destination/Tnew records for E and M and stalls D on RAW hazards.
// Optional multiply/divide busy tracking is compiled in when MD_STALL_EN is defined.
module hazard_scoreboard (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_D,
    output logic        stall,
    output logic        clr_E,
    output logic        md_busy
);

    typedef struct packed {
        logic [4:0] a3;
        logic [1:0] tnew;
    } rec_t;

    localparam rec_t BUBBLE = '{a3: 5'd0, tnew: 2'd0};

    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    function automatic logic src_hazard(input logic       used,
                                        input logic [4:0] r,
                                        input logic [1:0] tuse,
                                        input rec_t       rec);
        return used && (r != 5'd0) && (r == rec.a3) && (rec.tnew > tuse);
    endfunction

    logic [5:0] op_d;
    logic [5:0] funct_d;
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic [4:0] rd_d;
    logic       unused_shamt;

    assign op_d         = IR_D[31:26];
    assign rs_d         = IR_D[25:21];
    assign rt_d         = IR_D[20:16];
    assign rd_d         = IR_D[15:11];
    assign funct_d      = IR_D[5:0];
    assign unused_shamt = ^IR_D[10:6];

    logic is_special;
    logic is_jr;
    logic is_jalr;
    logic is_cal_r;
    logic is_cal_i;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jal;

    always_comb begin
        is_special = (op_d == 6'b000000);
        is_jr      = is_special && (funct_d == 6'b001000);
        is_jalr    = is_special && (funct_d == 6'b001001);
        is_cal_r   = (is_special || (op_d == 6'b011100)) && !is_jr && !is_jalr;
        is_cal_i   = (op_d[5:3] == 3'b001);
        is_load    = op_d inside {6'b100011, 6'b100000, 6'b100100, 6'b100001, 6'b100101};
        is_store   = op_d inside {6'b101011, 6'b101000, 6'b101001};
        is_branch  = op_d inside {6'b000100, 6'b000101, 6'b000110, 6'b000111, 6'b000001};
        is_jal     = (op_d == 6'b000011);
    end

    logic       rs_used;
    logic       rt_used;
    logic [1:0] rs_tuse;
    logic [1:0] rt_tuse;
    rec_t       rec_d;

    always_comb begin
        rs_used = is_branch || is_jr || is_jalr || is_cal_r || is_cal_i || is_load || is_store;
        rt_used = is_branch || is_cal_r || is_store;
        rs_tuse = (is_branch || is_jr || is_jalr) ? 2'd0 : 2'd1;
        if (is_branch)
            rt_tuse = 2'd0;
        else if (is_store)
            rt_tuse = 2'd2;
        else
            rt_tuse = 2'd1;

        rec_d = BUBBLE;
        if (is_cal_r)
            rec_d = '{a3: rd_d, tnew: 2'd1};
        else if (is_cal_i)
            rec_d = '{a3: rt_d, tnew: 2'd1};
        else if (is_load)
            rec_d = '{a3: rt_d, tnew: 2'd2};
        else if (is_jal)
            rec_d = '{a3: 5'd31, tnew: 2'd0};
        else if (is_jalr)
            rec_d = '{a3: rd_d, tnew: 2'd0};
    end

    rec_t rec_e_p1;
    rec_t rec_m_p2;
    logic raw_stall;
    logic md_stall;

    always_comb begin
        raw_stall = src_hazard(rs_used, rs_d, rs_tuse, rec_e_p1) ||
                    src_hazard(rt_used, rt_d, rt_tuse, rec_e_p1) ||
                    src_hazard(rs_used, rs_d, rs_tuse, rec_m_p2) ||
                    src_hazard(rt_used, rt_d, rt_tuse, rec_m_p2);
    end

    // D -> E -> M record pipeline; a stall loads a bubble into E
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rec_e_p1 <= BUBBLE;
            rec_m_p2 <= BUBBLE;
        end else begin
            rec_e_p1 <= stall ? BUBBLE : rec_d;
            rec_m_p2 <= '{a3: rec_e_p1.a3, tnew: sat_dec(rec_e_p1.tnew)};
        end
    end

`ifdef MD_STALL_EN
    typedef enum logic [1:0] {
        MD_NONE = 2'd0,
        MD_MULT = 2'd1,
        MD_DIV  = 2'd2
    } md_op_t;

    localparam logic [3:0] MULT_CYC = 4'd5;
    localparam logic [3:0] DIV_CYC  = 4'd10;

    md_op_t     md_op_d;
    md_op_t     md_op_e_p1;
    logic       md_class_d;
    logic [3:0] md_cnt;

    always_comb begin
        md_op_d = MD_NONE;
        if (is_special) begin
            case (funct_d)
                6'b011000, 6'b011001: md_op_d = MD_MULT;
                6'b011010, 6'b011011: md_op_d = MD_DIV;
                default:              md_op_d = MD_NONE;
            endcase
        end
        md_class_d = (md_op_d != MD_NONE) ||
                     (is_special && (funct_d inside {6'b010000, 6'b010010, 6'b010001, 6'b010011}));
    end

    // E-stage start op launches the busy counter at the following edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_op_e_p1 <= MD_NONE;
            md_cnt     <= 4'd0;
        end else begin
            md_op_e_p1 <= stall ? MD_NONE : md_op_d;
            if (md_op_e_p1 == MD_MULT)
                md_cnt <= MULT_CYC;
            else if (md_op_e_p1 == MD_DIV)
                md_cnt <= DIV_CYC;
            else if (md_cnt != 4'd0)
                md_cnt <= md_cnt - 4'd1;
        end
    end

    assign md_busy  = (md_cnt != 4'd0);
    assign md_stall = md_class_d && ((md_op_e_p1 != MD_NONE) || md_busy);
`else
    assign md_busy  = 1'b0;
    assign md_stall = 1'b0;
`endif

    // Gating with reset lets an in-flight stall collapse the moment reset is asserted.
    assign stall = reset && (raw_stall || md_stall);
    assign clr_E = stall;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: expected stall/md_busy pushed per driven instruction, popped at negedge.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR_D;
    logic        stall;
    logic        clr_E;
    logic        md_busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic stall;
        logic busy;
    } exp_t;

    exp_t exp_q[$];

`ifdef MD_STALL_EN
    localparam logic MD = 1'b1;
`else
    localparam logic MD = 1'b0;
`endif

    hazard_scoreboard dut (
        .clk     (clk),
        .reset   (reset),
        .IR_D    (IR_D),
        .stall   (stall),
        .clr_E   (clr_E),
        .md_busy (md_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lw(input logic [4:0] rt, input logic [4:0] rs);
        return {6'b100011, rs, rt, 16'h0000};
    endfunction
    function automatic logic [31:0] sw(input logic [4:0] rt, input logic [4:0] rs);
        return {6'b101011, rs, rt, 16'h0004};
    endfunction
    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [5:0] funct);
        return {6'b000000, rs, rt, rd, 5'd0, funct};
    endfunction
    function automatic logic [31:0] beq(input logic [4:0] rs, input logic [4:0] rt);
        return {6'b000100, rs, rt, 16'h0003};
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty, observed stall %b", tag, stall);
            return;
        end
        e = exp_q.pop_front();
        check({tag, ".stall"},   stall,   e.stall);
        check({tag, ".clr_E"},   clr_E,   e.stall);
        check({tag, ".md_busy"}, md_busy, e.busy);
    endtask

    task automatic step(input string tag, input logic [31:0] ir,
                        input logic exp_stall, input logic exp_busy);
        IR_D = ir;
        exp_q.push_back(exp_t'{exp_stall, exp_busy});
        @(negedge clk);
        compare_out(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        step("flush0", 32'h0, 1'b0, 1'b0);
        step("flush1", 32'h0, 1'b0, 1'b0);
    endtask

    logic [31:0] nop, add2, addu1, mult12, mflo3, div12, mfhi4, jal_i, jr31, jr5;
    logic [31:0] jalr7, add8, ori0, jmp, bgez1, addi76;

    initial begin
        nop    = 32'h0;
        add2   = rtype(5'd2, 5'd1, 5'd1, 6'b100000);
        addu1  = rtype(5'd1, 5'd2, 5'd3, 6'b100001);
        mult12 = rtype(5'd0, 5'd1, 5'd2, 6'b011000);
        div12  = rtype(5'd0, 5'd1, 5'd2, 6'b011010);
        mflo3  = rtype(5'd3, 5'd0, 5'd0, 6'b010010);
        mfhi4  = rtype(5'd4, 5'd0, 5'd0, 6'b010000);
        jal_i  = {6'b000011, 26'h0000010};
        jr31   = rtype(5'd0, 5'd31, 5'd0, 6'b001000);
        jr5    = rtype(5'd0, 5'd5, 5'd0, 6'b001000);
        jalr7  = rtype(5'd7, 5'd9, 5'd0, 6'b001001);
        add8   = rtype(5'd8, 5'd7, 5'd7, 6'b100000);
        ori0   = {6'b001101, 5'd1, 5'd0, 16'h0005};
        jmp    = {6'b000010, 5'd1, 5'd1, 16'h0000};
        bgez1  = {6'b000001, 5'd1, 5'd1, 16'h0002};
        addi76 = {6'b001000, 5'd6, 5'd7, 16'h0001};

        reset = 1'b0;
        IR_D  = nop;
        step("rst_nop",  nop,    1'b0, 1'b0);
        step("rst_lw",   lw(5'd1, 5'd0), 1'b0, 1'b0);
        step("rst_mult", mult12, 1'b0, 1'b0);
        reset = 1'b1;

        // load -> dependent cal, then cal -> dependent branch
        step("ld_cal_lw",   lw(5'd1, 5'd0), 1'b0, 1'b0);
        step("ld_cal_s1",   add2, 1'b1, 1'b0);
        step("ld_cal_go",   add2, 1'b0, 1'b0);
        step("add_beq_s1",  beq(5'd2, 5'd0), 1'b1, 1'b0);
        step("add_beq_go",  beq(5'd2, 5'd0), 1'b0, 1'b0);
        flush();

        step("ld_br_lw",  lw(5'd1, 5'd0), 1'b0, 1'b0);
        step("ld_br_s1",  beq(5'd1, 5'd0), 1'b1, 1'b0);
        step("ld_br_s2",  beq(5'd1, 5'd0), 1'b1, 1'b0);
        step("ld_br_go",  beq(5'd1, 5'd0), 1'b0, 1'b0);
        flush();

        step("cal_br_addu", addu1, 1'b0, 1'b0);
        step("cal_br_s1",   beq(5'd1, 5'd0), 1'b1, 1'b0);
        step("cal_br_go",   beq(5'd1, 5'd0), 1'b0, 1'b0);
        flush();

        step("cal_bgez_addu", addu1, 1'b0, 1'b0);
        step("cal_bgez_s1",   bgez1, 1'b1, 1'b0);
        step("cal_bgez_go",   bgez1, 1'b0, 1'b0);
        flush();

        step("ld_jr_lw", lw(5'd5, 5'd0), 1'b0, 1'b0);
        step("ld_jr_s1", jr5, 1'b1, 1'b0);
        step("ld_jr_s2", jr5, 1'b1, 1'b0);
        step("ld_jr_go", jr5, 1'b0, 1'b0);
        flush();

        step("ld_addi_lw", lw(5'd6, 5'd0), 1'b0, 1'b0);
        step("ld_addi_s1", addi76, 1'b1, 1'b0);
        step("ld_addi_go", addi76, 1'b0, 1'b0);
        flush();

        step("ld_sw_lw", lw(5'd3, 5'd0), 1'b0, 1'b0);
        step("ld_sw_rt", sw(5'd3, 5'd0), 1'b0, 1'b0);
        flush();

        step("ld_swbase_lw", lw(5'd4, 5'd0), 1'b0, 1'b0);
        step("ld_swbase_s1", sw(5'd0, 5'd4), 1'b1, 1'b0);
        step("ld_swbase_go", sw(5'd0, 5'd4), 1'b0, 1'b0);
        flush();

        step("jal_jr_jal",    jal_i, 1'b0, 1'b0);
        step("jal_jr_jr",     jr31,  1'b0, 1'b0);
        step("jalr_add_jalr", jalr7, 1'b0, 1'b0);
        step("jalr_add_add",  add8,  1'b0, 1'b0);
        flush();

        step("zero_ori", ori0, 1'b0, 1'b0);
        step("zero_add", rtype(5'd2, 5'd0, 5'd0, 6'b100000), 1'b0, 1'b0);
        step("zero_lw",  lw(5'd0, 5'd1), 1'b0, 1'b0);
        step("zero_beq", beq(5'd0, 5'd0), 1'b0, 1'b0);
        flush();

        step("m_stage_lw",  lw(5'd1, 5'd0), 1'b0, 1'b0);
        step("m_stage_nop", nop, 1'b0, 1'b0);
        step("m_stage_s1",  beq(5'd1, 5'd0), 1'b1, 1'b0);
        step("m_stage_go",  beq(5'd1, 5'd0), 1'b0, 1'b0);
        flush();

        step("w_stage_lw",  lw(5'd1, 5'd0), 1'b0, 1'b0);
        step("w_stage_n0",  nop, 1'b0, 1'b0);
        step("w_stage_n1",  nop, 1'b0, 1'b0);
        step("w_stage_beq", beq(5'd1, 5'd0), 1'b0, 1'b0);
        flush();

        step("unread_lw", lw(5'd1, 5'd0), 1'b0, 1'b0);
        step("unread_j",  jmp, 1'b0, 1'b0);
        flush();

        // multiply/divide sequences; expectations follow the build configuration
        step("mult_issue", mult12, 1'b0, 1'b0);
        step("mflo_c1", mflo3, MD, 1'b0);
        for (int i = 0; i < 5; i++) step("mflo_busy", mflo3, MD, MD);
        step("mflo_go", mflo3, 1'b0, 1'b0);
        flush();

        step("div_issue", div12, 1'b0, 1'b0);
        step("mfhi_c1", mfhi4, MD, 1'b0);
        for (int i = 0; i < 10; i++) step("mfhi_busy", mfhi4, MD, MD);
        step("mfhi_go", mfhi4, 1'b0, 1'b0);
        flush();

        // reset pulled during the second cycle of a load-branch stall
        step("ab_lw",   lw(5'd1, 5'd0), 1'b0, 1'b0);
        step("ab_beq1", beq(5'd1, 5'd0), 1'b1, 1'b0);
        IR_D = beq(5'd1, 5'd0);
        exp_q.push_back(exp_t'{1'b1, 1'b0});
        #1;
        compare_out("ab_beq2");
        reset = 1'b0;
        #1;
        exp_q.push_back(exp_t'{1'b0, 1'b0});
        compare_out("ab_rst_async");
        @(negedge clk);
        exp_q.push_back(exp_t'{1'b0, 1'b0});
        compare_out("ab_rst_hold");
        @(posedge clk);
        #1;
        reset = 1'b1;
        step("ab_post_beq",  beq(5'd1, 5'd0), 1'b0, 1'b0);
        flush();
        step("ab_post_lw",   lw(5'd1, 5'd0), 1'b0, 1'b0);
        step("ab_post_s1",   add2, 1'b1, 1'b0);
        step("ab_post_go",   add2, 1'b0, 1'b0);
        flush();

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d entries expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
